pll_cfg_seq: RTL and testbench

PLL_CFG_SEQ -- requirements
Module: pll_cfg_seq

---
 rtl/pll_cfg_seq_if.sv | 28 ++
 rtl/pll_cfg_seq.sv | 185 ++++++++++++++++++
 tb/tb_pll_cfg_seq.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_cfg_seq_if.sv
// pll_cfg_seq_if -- Avalon-MM management bus between the PLL configuration
// sequencer (master) and the PLL reconfiguration slave.
//
// Signals:
//   address     [5:0]  word address into the reconfig slave
//   writedata   [31:0] write data
//   write              write strobe
//   read               read strobe
//   waitrequest        slave stall; a transfer completes on a cycle with it low
//   readdata    [31:0] read data, valid when read=1 and waitrequest=0
interface pll_cfg_seq_if;
  logic [5:0]  address;
  logic [31:0] writedata;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, writedata, write, read,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, writedata, write, read,
    output waitrequest, readdata
  );
endinterface

// File: rtl/pll_cfg_seq.sv
// pll_cfg_seq -- reprograms a fractional PLL through its Avalon-MM reconfig
// slave. On request it writes mode, M, C0, C1, the fractional K word for the
// chosen profile and the start command; then polls the status register until
// the reconfig engine reports completion; then waits for the PLL to relock.
//
// Ports:
//   clk         sole clock (PLL reference clock domain)
//   rst_n       asynchronous active-low reset
//   cfg_req     one-cycle reconfiguration request (honoured only when idle)
//   cfg_sel     profile select (0: K0, 1: K1), sampled with cfg_req
//   pll_locked  asynchronous PLL lock flag
//   busy        sequence in progress
//   done        one-cycle completion pulse
//   err         sticky lock-timeout flag, cleared by the next accepted request
//   mgmt        Avalon-MM master port (pll_cfg_seq_if.master)
//
// Build option:
//   PLL_CFG_LOCK_TIMEOUT_EN  when defined, LOCK_WAIT gives up after
//                            LOCK_TIMEOUT cycles and raises err; otherwise
//                            LOCK_WAIT waits forever and err is tied low.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for cfg_req
// WRITE     | issuing the six configuration writes, indexed by step
// POLL      | reading status (0x01) until bit 0 reports completion
// LOCK_WAIT | waiting for the synchronised lock flag to be high 2 cycles
// FINISH    | one-cycle done pulse, then back to IDLE
module pll_cfg_seq #(
  parameter logic [31:0] K0           = 32'hAAC922F4,
  parameter logic [31:0] K1           = 32'hAA8F5C29,
  parameter logic [19:0] LOCK_TIMEOUT = 20'd1000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_req,
  input  logic          cfg_sel,
  input  logic          pll_locked,
  output logic          busy,
  output logic          done,
  output logic          err,
  pll_cfg_seq_if.master mgmt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    POLL      = 3'd2,
    LOCK_WAIT = 3'd3,
    FINISH    = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  step;
  logic        sel_q;
  logic        poll_gap;
  logic        sync_q1, sync_q2;
  logic        lock_hi;
  logic        tmo;
  logic        lock_ok;
  logic        wr_en, rd_en;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic        unused_rdata;

  assign unused_rdata = ^mgmt.readdata[31:1];

  // Two consecutive synchronised-high samples while in LOCK_WAIT.
  assign lock_ok = sync_q2 && lock_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    addr      = '0;
    wdata     = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (cfg_req) state_nxt = WRITE;
      end
      WRITE: begin
        wr_en = 1'b1;
        case (step)
          3'd0:    begin addr = 6'h00; wdata = 32'h0000_0001; end
          3'd1:    begin addr = 6'h04; wdata = 32'h0002_0504; end
          3'd2:    begin addr = 6'h05; wdata = 32'h0002_0302; end
          3'd3:    begin addr = 6'h05; wdata = 32'h0004_0505; end
          3'd4:    begin addr = 6'h07; wdata = sel_q ? K1 : K0; end
          3'd5:    begin addr = 6'h02; wdata = 32'h0000_0000; end
          default: begin addr = 6'h00; wdata = 32'h0000_0000; end
        endcase
        if (!mgmt.waitrequest && step == 3'd5) state_nxt = POLL;
      end
      POLL: begin
        rd_en = !poll_gap;
        if (rd_en) addr = 6'h01;
        if (rd_en && !mgmt.waitrequest && mgmt.readdata[0]) state_nxt = LOCK_WAIT;
      end
      LOCK_WAIT: begin
        if (lock_ok || tmo) state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mgmt.write     = wr_en;
  assign mgmt.read      = rd_en;
  assign mgmt.address   = addr;
  assign mgmt.writedata = wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step     <= '0;
      sel_q    <= 1'b0;
      poll_gap <= 1'b0;
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      lock_hi  <= 1'b0;
    end else begin
      sync_q1 <= pll_locked;
      sync_q2 <= sync_q1;
      lock_hi <= (state == LOCK_WAIT) && sync_q2;
      case (state)
        IDLE: begin
          if (cfg_req) begin
            sel_q    <= cfg_sel;
            step     <= '0;
            poll_gap <= 1'b0;
          end
        end
        WRITE: begin
          if (!mgmt.waitrequest) step <= step + 3'd1;
        end
        POLL: begin
          // A "not ready" status costs one idle cycle before the next read.
          if (poll_gap)                                  poll_gap <= 1'b0;
          else if (!mgmt.waitrequest && !mgmt.readdata[0]) poll_gap <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PLL_CFG_LOCK_TIMEOUT_EN
  logic [19:0] tmr;
  logic        err_q;

  // Down-counter reloaded outside LOCK_WAIT; terminal count on the
  // LOCK_TIMEOUT-th cycle spent in LOCK_WAIT.
  assign tmo = (state == LOCK_WAIT) && (tmr == '0);
  assign err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state != LOCK_WAIT)  tmr <= LOCK_TIMEOUT - 20'd1;
      else if (tmr != '0)      tmr <= tmr - 20'd1;

      if (state == IDLE && cfg_req) err_q <= 1'b0;
      else if (tmo && !lock_ok)     err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^LOCK_TIMEOUT;
  assign tmo            = 1'b0;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_pll_cfg_seq.sv
module tb_pll_cfg_seq;

  localparam logic [31:0] K0_V = 32'hAAC922F4;
  localparam logic [31:0] K1_V = 32'hAA8F5C29;

  logic clk = 1'b0;
  logic rst_n, cfg_req, cfg_sel, pll_locked;
  logic busy, done, err;

  pll_cfg_seq_if mgmt ();

  pll_cfg_seq #(.LOCK_TIMEOUT(20'd100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_req    (cfg_req),
    .cfg_sel    (cfg_sel),
    .pll_locked (pll_locked),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mgmt       (mgmt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // slave model / bus logger state
  int          cyc = 0;
  int          wait_cfg = 0;
  int          hold = 0;
  int          proto_err = 0;
  int          stab_err = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        done_err = 1'b0;
  logic [5:0]  h_addr;
  logic [31:0] h_data;
  logic [31:0] rd_q[$];
  logic [5:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          wr_len[$];
  logic [5:0]  rd_addr[$];
  int          rd_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    mgmt.waitrequest = 1'b0;
    mgmt.readdata    = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mgmt.write && mgmt.read) proto_err++;
      if (!mgmt.write && !mgmt.read && (mgmt.address != 6'h0 || mgmt.writedata != 32'h0))
        proto_err++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = err;
      end
      if (mgmt.write || mgmt.read) begin
        if (hold == 0) begin
          h_addr = mgmt.address;
          h_data = mgmt.writedata;
        end else if (mgmt.address != h_addr || mgmt.writedata != h_data) begin
          stab_err++;
        end
        if (mgmt.read) mgmt.readdata = (rd_q.size() > 0) ? rd_q[0] : 32'h1;
        if (hold < wait_cfg) begin
          mgmt.waitrequest = 1'b1;
          hold++;
        end else begin
          mgmt.waitrequest = 1'b0;
          if (mgmt.write) begin
            wr_addr.push_back(mgmt.address);
            wr_data.push_back(mgmt.writedata);
            wr_cyc.push_back(cyc);
            wr_len.push_back(hold + 1);
          end else begin
            rd_addr.push_back(mgmt.address);
            rd_cyc.push_back(cyc);
            if (rd_q.size() > 0) void'(rd_q.pop_front());
          end
          hold = 0;
        end
      end else begin
        mgmt.waitrequest = 1'b0;
        mgmt.readdata    = 32'h0;
        hold = 0;
      end
    end
  end

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); wr_len.delete();
    rd_addr.delete(); rd_cyc.delete(); rd_q.delete();
  endtask

  task automatic pulse_req(input logic sel);
    @(negedge clk); #1;
    cfg_sel = sel;
    cfg_req = 1'b1;
    @(negedge clk); #1;
    cfg_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n0, input int max);
    int i = 0;
    while (done_cnt == n0 && i < max) begin
      @(posedge clk);
      i++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != n0), 32'h1);
  endtask

  task automatic check_writes(input string tag, input logic [31:0] k, input int len);
    logic [5:0]  ea[6];
    logic [31:0] ed[6];
    ea = '{6'h00, 6'h04, 6'h05, 6'h05, 6'h07, 6'h02};
    ed = '{32'h1, 32'h00020504, 32'h00020302, 32'h00040505, k, 32'h0};
    chk({tag, "_nwr"}, 32'(wr_addr.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < wr_addr.size()) begin
        chk($sformatf("%s_wr%0d_addr", tag, i), 32'(wr_addr[i]), 32'(ea[i]));
        chk($sformatf("%s_wr%0d_data", tag, i), wr_data[i], ed[i]);
        chk($sformatf("%s_wr%0d_len", tag, i), 32'(wr_len[i]), 32'(len));
        if (i > 0)
          chk($sformatf("%s_wr%0d_gap", tag, i), 32'(wr_cyc[i] - wr_cyc[i-1]), 32'(len));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int raise_cyc;
    int i;
    rst_n = 1'b0; cfg_req = 1'b0; cfg_sel = 1'b0; pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_done",  32'(done), 32'h0);
    chk("rst_err",   32'(err), 32'h0);
    chk("rst_write", 32'(mgmt.write), 32'h0);
    chk("rst_read",  32'(mgmt.read), 32'h0);
    chk("rst_addr",  32'(mgmt.address), 32'h0);
    chk("rst_wdata", mgmt.writedata, 32'h0);

    // profile 0, no stalls, request on the first edge after reset release
    rd_q.push_back(32'h1);
    rst_n = 1'b1; cfg_req = 1'b1; cfg_sel = 1'b0;
    @(negedge clk); #1;
    cfg_req = 1'b0;
    chk("t1_busy_first_edge", 32'(busy), 32'h1);
    wait_done("t1", 0, 200);
    check_writes("t1", K0_V, 1);
    chk("t1_nrd", 32'(rd_addr.size()), 32'd1);
    if (rd_addr.size() == 1) begin
      chk("t1_rd_addr", 32'(rd_addr[0]), 32'h01);
      if (wr_cyc.size() == 6) chk("t1_rd_after_wr", 32'(rd_cyc[0] - wr_cyc[5]), 32'd1);
      chk("t1_done_lat", 32'(done_cyc - rd_cyc[0]), 32'd3);
    end
    chk("t1_err", 32'(done_err), 32'h0);
    repeat (3) @(negedge clk); #1;
    chk("t1_single_done", 32'(done_cnt), 32'd1);
    chk("t1_idle", 32'(busy), 32'h0);

    // profile 1, 3 stall cycles per transfer
    clear_logs();
    wait_cfg = 3;
    rd_q.push_back(32'h1);
    n0 = done_cnt;
    pulse_req(1'b1);
    wait_done("t2", n0, 400);
    check_writes("t2", K1_V, 4);
    chk("t2_stable", 32'(stab_err), 32'd0);
    chk("t2_nrd", 32'(rd_addr.size()), 32'd1);

    // status not ready twice
    @(posedge clk); #1;
    clear_logs();
    wait_cfg = 0;
    rd_q.push_back(32'h0); rd_q.push_back(32'h0); rd_q.push_back(32'h1);
    n0 = done_cnt;
    pulse_req(1'b0);
    wait_done("t3", n0, 200);
    chk("t3_nrd", 32'(rd_addr.size()), 32'd3);
    if (rd_addr.size() == 3) begin
      for (int j = 0; j < 3; j++) chk($sformatf("t3_rd%0d_addr", j), 32'(rd_addr[j]), 32'h01);
      chk("t3_rd_gap1", 32'(rd_cyc[1] - rd_cyc[0]), 32'd2);
      chk("t3_rd_gap2", 32'(rd_cyc[2] - rd_cyc[1]), 32'd2);
      chk("t3_done_lat", 32'(done_cyc - rd_cyc[2]), 32'd3);
    end

    // lock flag arrives late: synchroniser plus two-cycle qualification
    @(posedge clk); #1;
    clear_logs();
    pll_locked = 1'b0;
    rd_q.push_back(32'h1);
    n0 = done_cnt;
    pulse_req(1'b0);
    i = 0;
    while (rd_addr.size() == 0 && i < 100) begin @(posedge clk); i++; end
    repeat (10) @(negedge clk); #1;
    chk("t4_busy_unlocked", 32'(busy), 32'h1);
    chk("t4_no_done", 32'(done_cnt - n0), 32'd0);
    pll_locked = 1'b1;
    raise_cyc = cyc;
    wait_done("t4", n0, 100);
    chk("t4_lock_lat", 32'(done_cyc - raise_cyc), 32'd4);
    chk("t4_err", 32'(done_err), 32'h0);

`ifdef PLL_CFG_LOCK_TIMEOUT_EN
    // lock never arrives: timeout after 100 LOCK_WAIT cycles
    @(posedge clk); #1;
    clear_logs();
    pll_locked = 1'b0;
    rd_q.push_back(32'h1);
    n0 = done_cnt;
    pulse_req(1'b0);
    wait_done("t5", n0, 400);
    if (rd_cyc.size() == 1) chk("t5_tmo_lat", 32'(done_cyc - rd_cyc[0]), 32'd101);
    chk("t5_err_at_done", 32'(done_err), 32'h1);
    @(negedge clk); #1;
    chk("t5_err_sticky", 32'(err), 32'h1);
    chk("t5_idle", 32'(busy), 32'h0);
    pll_locked = 1'b1;
    n0 = done_cnt;
    pulse_req(1'b0);
    chk("t5_err_cleared", 32'(err), 32'h0);
    chk("t5_busy_again", 32'(busy), 32'h1);
    wait_done("t5b", n0, 200);
    chk("t5b_err", 32'(done_err), 32'h0);
`endif

    // reset during the fourth write
    @(posedge clk); #1;
    clear_logs();
    wait_cfg = 3;
    pll_locked = 1'b1;
    pulse_req(1'b0);
    i = 0;
    do begin
      @(posedge clk); #1;
      i++;
    end while (!(wr_addr.size() == 3 && mgmt.write) && i < 200);
    chk("t6_wr4_addr", 32'(mgmt.address), 32'h05);
    chk("t6_wr4_data", mgmt.writedata, 32'h00040505);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_write", 32'(mgmt.write), 32'h0);
    chk("t6_rst_read",  32'(mgmt.read), 32'h0);
    chk("t6_rst_busy",  32'(busy), 32'h0);
    chk("t6_rst_addr",  32'(mgmt.address), 32'h0);
    chk("t6_rst_wdata", mgmt.writedata, 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    clear_logs();
    wait_cfg = 0;
    n0 = done_cnt;
    pulse_req(1'b0);
    wait_done("t6", n0, 200);
    check_writes("t6", K0_V, 1);

    // requests while busy are ignored
    @(posedge clk); #1;
    clear_logs();
    n0 = done_cnt;
    pulse_req(1'b0);
    @(negedge clk); #1;
    cfg_sel = 1'b1;
    cfg_req = 1'b1;
    repeat (3) @(negedge clk); #1;
    cfg_req = 1'b0;
    cfg_sel = 1'b0;
    wait_done("t7", n0, 200);
    check_writes("t7", K0_V, 1);
    repeat (20) @(negedge clk); #1;
    chk("t7_single_done", 32'(done_cnt - n0), 32'd1);
    chk("t7_idle", 32'(busy), 32'h0);
    chk("t7_nwr_total", 32'(wr_addr.size()), 32'd6);

    chk("bus_protocol", 32'(proto_err), 32'd0);
    chk("bus_stable", 32'(stab_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
